multicycle_core: RTL
====================

Name: multicycle_core

Overview:
Parametrised multi-cycle successor to the single-cycle cpu top. It runs a FETCH/DECODE/EXECUTE/WRITEBACK state machine against an instruction-memory port with a valid handshake, so memory can insert wait states. It contains its own register file, ALU, branch unit and halt logic. It is the new top-level core and feeds a debug writeback port to the testbench.

Parameters:
XLEN, 32, datapath and register width (16 or 32)
PC_W, 8, PC width in words; instruction memory depth is 2^PC_W
RESET_PC, 0, word address loaded on reset
NREGS, 32, register count (16 or 32); rs/rd upper bits beyond log2(NREGS) ignored

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request
imem_req_addr  out  PC_W  word address of fetch
imem_rsp_valid  in  1  instruction data valid
imem_rsp_data  in  32  instruction word
wb_valid  out  1  one-cycle pulse when an instruction retires
wb_rd  out  5  destination of retiring instruction
wb_data  out  XLEN  value written (0 if no write)
pc_o  out  PC_W  current PC
halted  out  1  core stopped (ECALL or illegal)
illegal  out  1  halt cause was an illegal opcode

Behaviour:
- Reset (rst=0, async): state=FETCH, pc=RESET_PC, all registers=0, IR=0. All outputs 0 except imem_req_addr/pc_o=RESET_PC.
- FETCH: imem_req_valid=1 with addr=pc, held stable until imem_rsp_valid=1. A response in the same cycle as the request is accepted (zero-wait). On accept, IR<=imem_rsp_data and go to DECODE. imem_rsp_valid in any other state is ignored.
- DECODE: latch A=R[rs1], B=R[rs2]; decode opcode; generate sign-extended imm (I or B format). Illegal opcode goes to HALT with illegal=1.
- EXECUTE: ALU result latched. For branches, the compare is taken: target = pc + (sext(imm_b)>>>2), truncated to PC_W. Otherwise pc+1.
- WRITEBACK: if reg_write and rd!=0, R[rd]<=result. pc<=next. wb_valid=1 for this cycle only. Go to FETCH.
- HALT: terminal until reset; imem_req_valid=0; halted=1.
- Timing: minimum 4 cycles per instruction (CPI=4 + memory wait cycles). wb_valid fires in the 4th cycle after the request is first asserted, when there is zero wait.
- Supported instructions:
  - OP 0110011: ADD, SUB (funct7[5]), AND, OR, XOR, SLT, SLL, SRL.
  - OP-IMM 0010011: ADDI, ANDI, ORI, XORI, SLTI.
  - BRANCH 1100011: BEQ, BNE. Other funct3 values are illegal.
  - SYSTEM 0000073 (ECALL): goes to HALT, illegal=0, no wb_valid.
- Arithmetic: modulo 2^XLEN. SLT is signed. Shift amount is B[log2(XLEN)-1:0]. Immediates are sign-extended/truncated to XLEN.
- x0 reads 0 always; writes to x0 are dropped, but wb_valid still pulses with wb_data = computed value.
- PC increment and branch target both wrap modulo 2^PC_W.
- Reset mid-operation: any state returns immediately to FETCH at RESET_PC. An in-flight response is discarded; register file cleared.

Decomposition:
- Shared package (core_pkg): opcode constants, funct3/funct7 codes, ALU op enum, state enum (FETCH, DECODE, EXECUTE, WRITEBACK, HALT).
- One sub-module, core_alu: combinational, XLEN-parametrised, ALU op enum in, result and eq flag out.
- FSM, register file and immediate generation stay in multicycle_core.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> imem_req_valid=1, imem_req_addr=0, halted=0, wb_valid=0.
- Zero-wait fetch of ADDI x1,x0,5 (0x00500093) then ADDI x2,x0,-3 (0xFFD00113) -> wb pulses (rd=1, data=5) then (rd=2, data=0xFFFFFFFD), exactly 4 cycles apart.
- ADD x3,x1,x2 (0x002081B3) -> wb_data=2; SUB x4,x1,x2 (0x40208233) -> wb_data=8. ADDI x0,x0,7 -> wb_rd=0; later read of x0 gives 0.
- BEQ x0,x0,-4 (0xFE000EE3) at addr 5 -> next imem_req_addr=4. At addr 0 -> wraps to 2^PC_W-1=255.
- imem_rsp_valid delayed 3 cycles -> imem_req_addr held constant throughout; retire at cycle 7.
- ECALL (0x00000073) -> halted=1, illegal=0, imem_req_valid=0 forever. Opcode 0x7F -> halted=1, illegal=1. Assert rst during EXECUTE -> next fetch at addr 0 with registers cleared.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for multicycle_core: opcodes, function codes, ALU ops, FSM states
// and the instruction decoder.
package core_pkg;

    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] INSN_ECALL = 32'h0000_0073;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXECUTE, ST_WRITEBACK, ST_HALT
    } state_t;

    typedef struct packed {
        alu_op_t alu_op;
        logic    use_imm;
        logic    reg_write;
        logic    is_branch;
        logic    br_ne;
    } exe_ctl_t;

    typedef struct packed {
        exe_ctl_t exe;
        logic     is_ecall;
        logic     legal;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] insn);
        dec_t       d;
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        d   = '0;
        opc = insn[6:0];
        f3  = insn[14:12];
        f7  = insn[31:25];
        case (opc)
            OPC_OP: begin
                d.exe.reg_write = 1'b1;
                d.legal         = 1'b1;
                case (f3)
                    F3_ADD_SUB: d.exe.alu_op = f7[5] ? ALU_SUB : ALU_ADD;
                    F3_SLL:     d.exe.alu_op = ALU_SLL;
                    F3_SLT:     d.exe.alu_op = ALU_SLT;
                    F3_XOR:     d.exe.alu_op = ALU_XOR;
                    F3_SRL:     d.exe.alu_op = ALU_SRL;
                    F3_OR:      d.exe.alu_op = ALU_OR;
                    F3_AND:     d.exe.alu_op = ALU_AND;
                    default:    d.legal = 1'b0;
                endcase
                // funct7 alternate encoding is only meaningful for SUB
                if (f7 != F7_BASE && !(f7 == F7_ALT && f3 == F3_ADD_SUB))
                    d.legal = 1'b0;
            end
            OPC_OP_IMM: begin
                d.exe.reg_write = 1'b1;
                d.exe.use_imm   = 1'b1;
                d.legal         = 1'b1;
                case (f3)
                    F3_ADD_SUB: d.exe.alu_op = ALU_ADD;
                    F3_SLT:     d.exe.alu_op = ALU_SLT;
                    F3_XOR:     d.exe.alu_op = ALU_XOR;
                    F3_OR:      d.exe.alu_op = ALU_OR;
                    F3_AND:     d.exe.alu_op = ALU_AND;
                    default:    d.legal = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                d.exe.is_branch = 1'b1;
                d.exe.alu_op    = ALU_SUB;
                d.exe.br_ne     = (f3 == F3_BNE);
                d.legal         = (f3 == F3_BEQ) || (f3 == F3_BNE);
            end
            OPC_SYSTEM: begin
                if (insn == INSN_ECALL) begin
                    d.is_ecall = 1'b1;
                    d.legal    = 1'b1;
                end
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/core_alu.sv
// Purpose: XLEN-wide integer ALU with an equality flag for branch compares.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
module core_alu
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_t          op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  result,
    output logic             eq
);

    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;
    logic            lt;

    always_comb begin
        shamt  = b[SH_W-1:0];
        lt     = $signed(a) < $signed(b);
        eq     = (a == b);
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, lt};
            ALU_SLL: result = a << shamt;
            ALU_SRL: result = a >> shamt;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_core.sv
// Purpose: multi-cycle core running FETCH/DECODE/EXECUTE/WRITEBACK with its own register file.
// Latency: 4 cycles per instruction plus any instruction-memory wait cycles.
// Backpressure: fetch request and address held until imem_rsp_valid; core stalls in FETCH meanwhile.
module multicycle_core
    import core_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0,
    parameter int NREGS    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic [PC_W-1:0]   pc_o,
    output logic              halted,
    output logic              illegal
);

    localparam int              RIDX_W = $clog2(NREGS);
    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, next_pc_q, br_tgt;
    logic [31:0]       ir_q;
    logic [XLEN-1:0]   regs_q [NREGS];
    logic [XLEN-1:0]   a_q, b_q, imm_q, result_q;
    logic [XLEN-1:0]   imm_i, imm_b, rs1_val, rs2_val;
    logic [XLEN-1:0]   alu_b, alu_res;
    logic              alu_eq, br_taken;
    logic [4:0]        rd_q;
    logic              illegal_q;
    exe_ctl_t          ctl_q;
    dec_t              dec_dat;
    logic [RIDX_W-1:0] rs1_idx, rs2_idx, rd_idx;

    assign dec_dat = decode(ir_q);
    assign rs1_idx = ir_q[15 +: RIDX_W];
    assign rs2_idx = ir_q[20 +: RIDX_W];
    assign rd_idx  = rd_q[RIDX_W-1:0];
    assign rs1_val = (rs1_idx == '0) ? '0 : regs_q[rs1_idx];
    assign rs2_val = (rs2_idx == '0) ? '0 : regs_q[rs2_idx];

    assign imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    assign imm_b = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

    assign alu_b = ctl_q.use_imm ? imm_q : b_q;

    core_alu #(.XLEN(XLEN)) u_alu (
        .op     (ctl_q.alu_op),
        .a      (a_q),
        .b      (alu_b),
        .result (alu_res),
        .eq     (alu_eq)
    );

    // Byte offset converted to a word offset; the add wraps at 2^PC_W.
    assign br_tgt   = pc_q + PC_W'($signed(imm_q) >>> 2);
    assign br_taken = ctl_q.is_branch && (alu_eq ^ ctl_q.br_ne);

    always_comb begin
        state_d        = state_q;
        imem_req_valid = 1'b0;
        wb_valid       = 1'b0;
        wb_rd          = '0;
        wb_data        = '0;
        case (state_q)
            ST_FETCH: begin
                imem_req_valid = rst;
                if (imem_rsp_valid) state_d = ST_DECODE;
            end
            ST_DECODE:    state_d = (!dec_dat.legal || dec_dat.is_ecall) ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:   state_d = ST_WRITEBACK;
            ST_WRITEBACK: begin
                state_d  = ST_FETCH;
                wb_valid = 1'b1;
                if (ctl_q.reg_write) begin
                    wb_rd   = rd_q;
                    wb_data = result_q;
                end
            end
            ST_HALT:      state_d = ST_HALT;
            default:      state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= PC_RST;
            next_pc_q <= PC_RST;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            result_q  <= '0;
            rd_q      <= '0;
            ctl_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_FETCH: if (imem_rsp_valid) ir_q <= imem_rsp_data;
                ST_DECODE: begin
                    a_q   <= rs1_val;
                    b_q   <= rs2_val;
                    imm_q <= dec_dat.exe.is_branch ? imm_b : imm_i;
                    ctl_q <= dec_dat.exe;
                    rd_q  <= ir_q[11:7];
                    if (!dec_dat.legal) illegal_q <= 1'b1;
                end
                ST_EXECUTE: begin
                    result_q  <= alu_res;
                    next_pc_q <= br_taken ? br_tgt : pc_q + PC_W'(1);
                end
                ST_WRITEBACK: pc_q <= next_pc_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (state_q == ST_WRITEBACK && ctl_q.reg_write && rd_idx != '0) begin
            regs_q[rd_idx] <= result_q;
        end
    end

    assign imem_req_addr = pc_q;
    assign pc_o          = pc_q;
    assign halted        = (state_q == ST_HALT);
    assign illegal       = illegal_q;

endmodule
